// File: rtl/tl_mon_pkg.sv
// tl_mon_pkg: phase encoding, tracker FSM states and phase-order helpers
// shared by the traffic light monitor and its light decoder.
package tl_mon_pkg;

    localparam logic [1:0] PH_NONE = 2'b00;
    localparam logic [1:0] PH_G    = 2'b01;
    localparam logic [1:0] PH_Y    = 2'b10;
    localparam logic [1:0] PH_R    = 2'b11;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRK_G = 2'd1,
        TRK_Y = 2'd2,
        TRK_R = 2'd3
    } state_t;

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        case (p)
            PH_G:    next_phase = PH_Y;
            PH_Y:    next_phase = PH_R;
            PH_R:    next_phase = PH_G;
            default: next_phase = PH_NONE;
        endcase
    endfunction

    function automatic state_t trk_state(input logic [1:0] p);
        case (p)
            PH_G:    trk_state = TRK_G;
            PH_Y:    trk_state = TRK_Y;
            PH_R:    trk_state = TRK_R;
            default: trk_state = SYNC;
        endcase
    endfunction

    function automatic logic [1:0] trk_phase(input state_t s);
        case (s)
            TRK_G:   trk_phase = PH_G;
            TRK_Y:   trk_phase = PH_Y;
            TRK_R:   trk_phase = PH_R;
            default: trk_phase = PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tl_light_decode.sv
// tl_light_decode: one-hot check and phase encode of the light lines.
// Ports: clk, reset (async high), green/red/yellow in; ph_now and bad_now
// are the combinational decode of the current sample, phase is the
// registered decode (previous sample as seen by the monitor).
module tl_light_decode
    import tl_mon_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       green,
    input  logic       red,
    input  logic       yellow,
    output logic [1:0] ph_now,
    output logic       bad_now,
    output logic [1:0] phase
);

    always_comb begin
        ph_now  = PH_NONE;
        bad_now = 1'b1;
        case ({green, yellow, red})
            3'b100: begin ph_now = PH_G; bad_now = 1'b0; end
            3'b010: begin ph_now = PH_Y; bad_now = 1'b0; end
            3'b001: begin ph_now = PH_R; bad_now = 1'b0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) phase <= PH_NONE;
        else       phase <= ph_now;
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for the traffic light output bus.
// Ports: clk, reset (async high), clr (sync clear of flags/counters),
// green/red/yellow_light, cnt in; phase, locked, err_onehot, err_seq,
// err_len, err_cnt, err_pulse, cycles, err_total out (all registered).
// Option: define TL_MON_ERR_TOTAL_EN to build the err_total event counter.
module traffic_light_monitor
    import tl_mon_pkg::*;
#(
    parameter int GREEN_LEN  = 6,
    parameter int YELLOW_LEN = 2,
    parameter int RED_LEN    = 4,
    parameter int CYC_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             green_light,
    input  logic             red_light,
    input  logic             yellow_light,
    input  logic [3:0]       cnt,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_len,
    output logic             err_cnt,
    output logic             err_pulse,
    output logic [CYC_W-1:0] cycles,
    output logic [7:0]       err_total
);

    function automatic logic [4:0] len_of(input logic [1:0] p);
        case (p)
            PH_G:    len_of = 5'(GREEN_LEN);
            PH_Y:    len_of = 5'(YELLOW_LEN);
            PH_R:    len_of = 5'(RED_LEN);
            default: len_of = 5'd0;
        endcase
    endfunction

    state_t     state, state_nx;
    logic [1:0] ph_now, ph_prev, cur_ph;
    logic       bad_now, changed, legal, start, chk, inc;
    logic       ev_oh, ev_seq, ev_len, ev_cnt, ev_any;
    logic [4:0] dur, dur_nx, cur_len, new_len, exp_cnt;
    logic       cnt_chk, cnt_chk_nx;
    logic       len_done, len_done_nx;
    logic       cyc_ok, cyc_ok_nx;

    tl_light_decode u_dec (
        .clk     (clk),
        .reset   (reset),
        .green   (green_light),
        .red     (red_light),
        .yellow  (yellow_light),
        .ph_now  (ph_now),
        .bad_now (bad_now),
        .phase   (ph_prev)
    );

    assign phase   = ph_prev;
    assign cur_len = len_of(cur_ph);
    assign new_len = len_of(ph_now);
    // A change only counts between two legal samples.
    assign changed = !bad_now && ph_prev != PH_NONE && ph_now != ph_prev;
    assign legal   = ph_now == next_phase(cur_ph);
    assign start   = changed && (state == SYNC || legal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SYNC;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bad_now)
            state_nx = SYNC;
        else if (changed)
            state_nx = (state == SYNC || legal) ? trk_state(ph_now) : SYNC;
    end

    always_comb begin
        cur_ph = trk_phase(state);
        locked = state != SYNC;
    end

    always_comb begin
        dur_nx      = dur;
        cnt_chk_nx  = cnt_chk;
        len_done_nx = len_done;
        cyc_ok_nx   = cyc_ok;
        ev_oh       = 1'b0;
        ev_seq      = 1'b0;
        ev_len      = 1'b0;
        ev_cnt      = 1'b0;
        inc         = 1'b0;
        chk         = 1'b0;
        exp_cnt     = 5'd0;
        if (bad_now) begin
            ev_oh      = 1'b1;
            dur_nx     = 5'd0;
            cnt_chk_nx = 1'b0;
        end else if (state != SYNC) begin
            if (!changed) begin
                if (dur != 5'd31) dur_nx = dur + 5'd1;
                if (dur_nx > cur_len && !len_done) begin
                    ev_len      = 1'b1;
                    len_done_nx = 1'b1;
                end
                // Past the nominal length only err_len applies.
                chk     = cnt_chk && dur_nx <= cur_len;
                exp_cnt = cur_len - dur_nx;
            end else if (legal) begin
                // Overlong phases were flagged already while running.
                if (dur < cur_len) ev_len = 1'b1;
                if (ph_now == PH_G) inc = cyc_ok && !ev_len;
            end else begin
                ev_seq     = 1'b1;
                dur_nx     = 5'd0;
                cnt_chk_nx = 1'b0;
            end
        end
        if (start) begin
            dur_nx      = 5'd1;
            len_done_nx = 1'b0;
            cnt_chk_nx  = 1'b1;
            chk         = 1'b1;
            exp_cnt     = new_len - 5'd1;
        end
        if (chk && {1'b0, cnt} != exp_cnt) begin
            ev_cnt     = 1'b1;
            cnt_chk_nx = 1'b0;
        end
        ev_any = ev_oh | ev_seq | ev_len | ev_cnt;
        if (ev_any || state_nx == SYNC) cyc_ok_nx = 1'b0;
        // A new G opens a fresh cycle; only its own cnt error spoils it.
        if (start && ph_now == PH_G) cyc_ok_nx = !ev_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dur        <= 5'd0;
            cnt_chk    <= 1'b0;
            len_done   <= 1'b0;
            cyc_ok     <= 1'b0;
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
            err_len    <= 1'b0;
            err_cnt    <= 1'b0;
            err_pulse  <= 1'b0;
            cycles     <= '0;
        end else begin
            dur        <= dur_nx;
            cnt_chk    <= cnt_chk_nx;
            len_done   <= len_done_nx;
            cyc_ok     <= cyc_ok_nx;
            err_onehot <= (err_onehot & ~clr) | ev_oh;
            err_seq    <= (err_seq & ~clr) | ev_seq;
            err_len    <= (err_len & ~clr) | ev_len;
            err_cnt    <= (err_cnt & ~clr) | ev_cnt;
            err_pulse  <= ev_any;
            if (clr)
                cycles <= CYC_W'(inc);
            else if (inc && cycles != '1)
                cycles <= cycles + 1'b1;
        end
    end

`ifdef TL_MON_ERR_TOTAL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_total <= 8'd0;
        else if (clr)
            err_total <= {7'd0, ev_any};
        else if (ev_any && err_total != 8'hFF)
            err_total <= err_total + 8'd1;
    end
`else
    assign err_total = 8'd0;
`endif

endmodule
